// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase accumulator slice.
package dds_pkg;

    localparam int ACC_W_DEF   = 24;
    localparam int PHASE_W_DEF = 14;

    // Load target select on the first byte of a load.
    localparam logic LD_SEL_FTW = 1'b0;
    localparam logic LD_SEL_OFF = 1'b1;

    // Byte counts for the default widths; the offset is always two bytes.
    localparam int FTW_BYTES = ACC_W_DEF / 8;
    localparam int OFF_BYTES = 2;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_PEND    = 2'd2
    } ld_state_e;

endpackage

// File: rtl/dds_byte_loader.sv
// Byte-serial loader for the FTW and phase offset: collects LSB-first bytes
// into shadow registers and emits a commit strobe on the first tick after
// the last byte, so the active registers only change on a sample boundary.
module dds_byte_loader
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               ld_valid_i,
    input  logic               ld_sel_i,
    input  logic [7:0]         ld_data_i,
    input  logic               ld_clr_i,
    output logic               ld_ready_o,
    output logic               busy_o,
    output logic               commit_ftw_o,
    output logic               commit_off_o,
    output logic [ACC_W-1:0]   ftw_sh_o,
    output logic [PHASE_W-1:0] off_sh_o
);

    localparam int N_FTW = ACC_W / 8;
    localparam int MAXB  = (N_FTW > OFF_BYTES) ? N_FTW : OFF_BYTES;
    localparam int CNT_W = $clog2(MAXB);

    ld_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               ready_q;
    logic [ACC_W-1:0]   ftw_sh_q;
    logic [PHASE_W-1:0] off_sh_q;

    logic               hs;
    logic               cur_sel;
    logic [CNT_W-1:0]   last_idx;
    logic [CNT_W-1:0]   widx;
    logic               commit;

    // A clear on the same cycle as a valid byte suppresses the handshake.
    assign hs       = ld_valid_i && ready_q && !ld_clr_i;
    // The target select is only taken from the port on the first byte.
    assign cur_sel  = (state_q == LD_IDLE) ? ld_sel_i : sel_q;
    assign last_idx = (cur_sel == LD_SEL_OFF) ? CNT_W'(OFF_BYTES - 1) : CNT_W'(N_FTW - 1);
    assign widx     = (state_q == LD_IDLE) ? '0 : cnt_q;

    // Loader next-state: IDLE -> COLLECT -> PEND -> (tick) -> IDLE; clear wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        commit  = 1'b0;
        if (ld_clr_i) begin
            state_d = LD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (hs) begin
                        sel_d = ld_sel_i;
                        if (last_idx == '0) begin
                            state_d = LD_PEND;
                        end else begin
                            state_d = LD_COLLECT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                LD_COLLECT: begin
                    if (hs) begin
                        if (cnt_q == last_idx) begin
                            state_d = LD_PEND;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LD_PEND: begin
                    if (tick_i) begin
                        commit  = 1'b1;
                        state_d = LD_IDLE;
                    end
                end
                default: begin
                    state_d = LD_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and ready; ready is registered from the next state so it
    // drops the cycle after the last byte and has no path from ld_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            sel_q   <= LD_SEL_FTW;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ready_q <= (state_d != LD_PEND);
        end
    end

    // Shadow registers: each accepted byte lands at its LSB-first position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ftw_sh_q <= '0;
            off_sh_q <= '0;
        end else if (hs) begin
            for (int b = 0; b < N_FTW; b++) begin
                if (cur_sel == LD_SEL_FTW && widx == CNT_W'(b))
                    ftw_sh_q[b*8 +: 8] <= ld_data_i;
            end
            for (int i = 0; i < PHASE_W; i++) begin
                if (cur_sel == LD_SEL_OFF && widx == CNT_W'(i / 8))
                    off_sh_q[i] <= ld_data_i[i % 8];
            end
        end
    end

    assign ld_ready_o   = ready_q;
    assign busy_o       = (state_q != LD_IDLE);
    assign commit_ftw_o = commit && (sel_q == LD_SEL_FTW);
    assign commit_off_o = commit && (sel_q == LD_SEL_OFF);
    assign ftw_sh_o     = ftw_sh_q;
    assign off_sh_o     = off_sh_q;

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: tick divider, wrapping FTW accumulator and a
// registered truncate-plus-offset stage feeding the sine lookup.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DIV     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_sel,
    input  logic [7:0]         ld_data,
    input  logic               ld_clr,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               busy
);

    localparam int               DIV_W      = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_q;
    logic [PHASE_W-1:0] off_q;
    logic [PHASE_W-1:0] off_s_q;
    logic [1:0]         vld_pipe_q;
    logic [PHASE_W-1:0] phase_q, phase_d;

    logic               tick;
    logic               upd;
    logic               commit_ftw, commit_off;
    logic [ACC_W-1:0]   ftw_sh;
    logic [PHASE_W-1:0] off_sh;

    assign tick = en && (div_q == '0);
    // Either a tick or a sync changes acc, so both produce a phase sample.
    assign upd  = tick || sync;

    dds_byte_loader #(
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W)
    ) u_loader (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .ld_valid_i   (ld_valid),
        .ld_sel_i     (ld_sel),
        .ld_data_i    (ld_data),
        .ld_clr_i     (ld_clr),
        .ld_ready_o   (ld_ready),
        .busy_o       (busy),
        .commit_ftw_o (commit_ftw),
        .commit_off_o (commit_off),
        .ftw_sh_o     (ftw_sh),
        .off_sh_o     (off_sh)
    );

    // Divider and accumulator next-state; sync overrides a coincident tick.
    always_comb begin
        div_d = div_q;
        acc_d = acc_q;
        if (sync) begin
            acc_d = '0;
            div_d = DIV_RELOAD;
        end else if (en) begin
            if (tick) begin
                acc_d = acc_q + ftw_q;
                div_d = DIV_RELOAD;
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    // Offset is the one captured with the acc update, so a commit on tick t
    // only affects the phase of later ticks.
    assign phase_d = acc_q[ACC_W-1 -: PHASE_W] + off_s_q;

    // Accumulator, active registers and the two-stage phase pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            acc_q      <= '0;
            ftw_q      <= '0;
            off_q      <= '0;
            off_s_q    <= '0;
            vld_pipe_q <= '0;
            phase_q    <= '0;
        end else begin
            div_q      <= div_d;
            acc_q      <= acc_d;
            vld_pipe_q <= {vld_pipe_q[0], upd};
            if (upd)
                off_s_q <= off_q;
            if (vld_pipe_q[0])
                phase_q <= phase_d;
            if (commit_ftw)
                ftw_q <= ftw_sh;
            if (commit_off)
                off_q <= off_sh;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = vld_pipe_q[1];

endmodule
